// File: rtl/kv_codec_pkg.sv
// kv_codec_pkg: shared constants, state type and quantizer helpers for kv_compress / kv_decompress.
package kv_codec_pkg;
  localparam int KV_D       = 128;
  localparam int KV_IN_W    = 16;
  localparam int KV_OUT_W   = 8;
  localparam int KV_SCALE_W = 16;
  localparam int KV_LANES   = 16;
  localparam int Q_MAX      = 127;
  localparam int RECIP_FRAC = 16;
  localparam int RECIP_W    = 23;
  localparam int ABS_MAX    = 32767;
  typedef enum logic [2:0] {IDLE, MAX, DIV, QUANT, DELTA, OUT} kvc_state_t;
  function automatic logic [14:0] sat_abs(input logic signed [15:0] x);
    return x == 16'sh8000 ? 15'(ABS_MAX) : 15'(x[15] ? -x : x);
  endfunction
  // Round-half-up of |x|*recip in Q16, clamped so -128 can never appear.
  function automatic logic signed [7:0] quant(input logic signed [15:0] x, input logic [RECIP_W-1:0] recip);
    logic [37:0] r;
    r = (38'(sat_abs(x)) * 38'(recip) + 38'(1 << (RECIP_FRAC - 1))) >> RECIP_FRAC;
    r = r > 38'(Q_MAX) ? 38'(Q_MAX) : r;
    return x[15] ? -8'(r) : 8'(r);
  endfunction
endpackage

// File: rtl/kv_recip_div.sv
// kv_recip_div: sequential restoring divider, one quotient bit per cycle, done on the final step.
module kv_recip_div
  import kv_codec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [RECIP_W-1:0]    num_i,
  input  logic [KV_SCALE_W-1:0] den_i,
  output logic                  done_o,
  output logic [RECIP_W-1:0]    quot_o
);
  logic [RECIP_W-1:0] q_q;
  logic [KV_SCALE_W-1:0] den_q, rem_q;
  logic [4:0] cnt_q;
  logic busy_q, fit;
  logic [KV_SCALE_W:0] trial, diff;
  always_comb begin
    trial = {rem_q, q_q[RECIP_W-1]};
    diff = trial - {1'b0, den_q};
    fit = trial >= {1'b0, den_q};
  end
  assign done_o = busy_q && cnt_q == 5'(RECIP_W - 1);
  assign quot_o = q_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
      den_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      q_q <= num_i;
      den_q <= den_i;
      rem_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      q_q <= {q_q[RECIP_W-2:0], fit};
      rem_q <= fit ? diff[KV_SCALE_W-1:0] : trial[KV_SCALE_W-1:0];
      cnt_q <= cnt_q + 5'd1;
      busy_q <= !done_o;
    end
  end
endmodule

// File: rtl/kv_compress.sv
// kv_compress: INT8 max-abs quantizer + mod-256 delta encoder for one KV vector at a time.
// Optional KV_COMPRESS_STATS_EN adds saturating handshake / zero-scale counters.
module kv_compress
  import kv_codec_pkg::*;
#(
  parameter int D       = KV_D,
  parameter int IN_W    = KV_IN_W,
  parameter int OUT_W   = KV_OUT_W,
  parameter int SCALE_W = KV_SCALE_W,
  parameter int LANES   = KV_LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [IN_W*D-1:0]    s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [OUT_W*D-1:0]   m_axis_tdata,
  output logic [SCALE_W-1:0]   m_axis_tscale,
  output logic                 m_axis_tlast
`ifdef KV_COMPRESS_STATS_EN
  ,
  output logic [31:0]          stat_vec_cnt,
  output logic [31:0]          stat_zero_cnt
`endif
);
  localparam int NB = D / LANES;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam int QW = OUT_W * D;
  kvc_state_t state_q, state_d;
  logic [IN_W*D-1:0] data_q;
  logic tlast_q;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [IW-1:0] idx_q;
  logic [QW-1:0] q_q, tdata_q, delta_d;
  logic [OUT_W*LANES-1:0] lanes_d;
  logic [RECIP_W-1:0] quot, recip;
  logic [OUT_W-1:0] prev;
  logic div_start, div_done, s_hs, m_hs, quant_last;
  kv_recip_div u_div (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(div_start),
    .num_i(RECIP_W'(Q_MAX << RECIP_FRAC)),
    .den_i(scale_d),
    .done_o(div_done),
    .quot_o(quot)
  );
  assign recip = scale_q == '0 ? '0 : quot;
  assign quant_last = idx_q == IW'(NB - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = s_axis_tvalid ? MAX : IDLE;
      MAX:     state_d = scale_d == '0 ? QUANT : DIV;
      DIV:     state_d = div_done ? QUANT : DIV;
      QUANT:   state_d = quant_last ? DELTA : QUANT;
      DELTA:   state_d = OUT;
      OUT:     state_d = m_axis_tready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    s_axis_tready = state_q == IDLE;
    m_axis_tvalid = state_q == OUT;
    div_start = state_q == MAX && scale_d != '0;
  end
  assign s_hs = s_axis_tvalid && s_axis_tready;
  assign m_hs = m_axis_tvalid && m_axis_tready;
  always_comb begin
    scale_d = '0;
    for (int i = 0; i < D; i++)
      scale_d = SCALE_W'(sat_abs(data_q[i*IN_W +: IN_W])) > scale_d ? SCALE_W'(sat_abs(data_q[i*IN_W +: IN_W])) : scale_d;
  end
  // Quantizer always reads the low LANES elements; the buffer shifts down each QUANT cycle.
  always_comb begin
    lanes_d = '0;
    for (int l = 0; l < LANES; l++) lanes_d[l*OUT_W +: OUT_W] = quant(data_q[l*IN_W +: IN_W], recip);
  end
  always_comb begin
    delta_d = '0;
    prev = '0;
    for (int i = 0; i < D; i++) begin
      delta_d[i*OUT_W +: OUT_W] = q_q[i*OUT_W +: OUT_W] - prev;
      prev = q_q[i*OUT_W +: OUT_W];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      tlast_q <= 1'b0;
      scale_q <= '0;
      idx_q <= '0;
      q_q <= '0;
      tdata_q <= '0;
    end else begin
      if (s_hs) begin
        data_q <= s_axis_tdata;
        tlast_q <= s_axis_tlast;
      end
      if (state_q == MAX) begin
        scale_q <= scale_d;
        idx_q <= '0;
      end
      if (state_q == QUANT) begin
        data_q <= data_q >> (IN_W * LANES);
        q_q <= QW'({lanes_d, q_q} >> (OUT_W * LANES));
        idx_q <= idx_q + 1'b1;
      end
      if (state_q == DELTA) tdata_q <= delta_d;
    end
  end
  assign m_axis_tdata = tdata_q;
  assign m_axis_tscale = scale_q;
  assign m_axis_tlast = tlast_q;
`ifdef KV_COMPRESS_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_vec_cnt <= '0;
      stat_zero_cnt <= '0;
    end else if (m_hs) begin
      stat_vec_cnt <= stat_vec_cnt + 32'(stat_vec_cnt != '1);
      stat_zero_cnt <= stat_zero_cnt + 32'(scale_q == '0 && stat_zero_cnt != '1);
    end
  end
`endif
endmodule

// File: tb/tb_kv_compress.sv
// tb_kv_compress: table-driven directed vectors plus stall and mid-vector reset sequences.
module tb_kv_compress;
  localparam int D = 128, IN_W = 16, OUT_W = 8, SCALE_W = 16;
  typedef struct {
    logic [IN_W*D-1:0]  data;
    logic               last;
    logic [SCALE_W-1:0] scale;
    logic [OUT_W*D-1:0] bytes;
    int                 lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [IN_W*D-1:0] s_axis_tdata = '0;
  logic s_axis_tlast = 1'b0;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b0;
  logic [OUT_W*D-1:0] m_axis_tdata;
  logic [SCALE_W-1:0] m_axis_tscale;
  logic m_axis_tlast;
`ifdef KV_COMPRESS_STATS_EN
  logic [31:0] stat_vec_cnt, stat_zero_cnt;
`endif
  int applied = 0;
  int miscompares = 0;
  vec_t tv[6];
  always #5 clk = ~clk;
  kv_compress dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tscale(m_axis_tscale),
    .m_axis_tlast(m_axis_tlast)
`ifdef KV_COMPRESS_STATS_EN
    ,
    .stat_vec_cnt(stat_vec_cnt),
    .stat_zero_cnt(stat_zero_cnt)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    applied++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  task automatic check_bytes(input string name, input logic [OUT_W*D-1:0] exp);
    int bad = -1;
    applied++;
    for (int i = D - 1; i >= 0; i--)
      if (m_axis_tdata[i*OUT_W +: OUT_W] !== exp[i*OUT_W +: OUT_W]) bad = i;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s: byte %0d got %02h, expected %02h", name, bad, m_axis_tdata[bad*OUT_W +: OUT_W], exp[bad*OUT_W +: OUT_W]);
    end
  endtask
  // Cycle 1 is the cycle that starts at the accepting edge.
  task automatic send(input vec_t v, input string name);
    int lat;
    check({name, " in_ready"}, s_axis_tready, 1);
    s_axis_tdata = v.data;
    s_axis_tlast = v.last;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    lat = 1;
    while (!m_axis_tvalid && lat < 200) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, v.lat);
    check({name, " scale"}, m_axis_tscale, v.scale);
    check({name, " tlast"}, m_axis_tlast, v.last);
    check_bytes({name, " tdata"}, v.bytes);
  endtask
  task automatic finish_hs(input string name);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    check({name, " tvalid_drop"}, m_axis_tvalid, 0);
    check({name, " ready_back"}, s_axis_tready, 1);
  endtask
  initial begin
    for (int i = 0; i < 6; i++) begin
      tv[i].data = '0;
      tv[i].bytes = '0;
      tv[i].last = 1'b0;
      tv[i].scale = '0;
      tv[i].lat = 34;
    end
    tv[0].last = 1'b1;
    tv[0].lat = 11;
    for (int i = 0; i < D; i++) tv[1].data[i*IN_W +: IN_W] = 16'(100 * i);
    for (int i = 1; i < D; i++) tv[1].bytes[i*OUT_W +: OUT_W] = 8'h01;
    tv[1].scale = 16'd12700;
    tv[2].data[15:0] = 16'd1000;
    tv[2].data[31:16] = 16'hFC18;
    tv[2].last = 1'b1;
    tv[2].scale = 16'd1000;
    tv[2].bytes[23:0] = 24'h7F027F;
    tv[3].data[15:0] = 16'h8000;
    tv[3].scale = 16'd32767;
    tv[3].bytes[15:0] = 16'h7F81;
    for (int i = 0; i < D; i++) tv[4].data[i*IN_W +: IN_W] = 16'd127;
    tv[4].scale = 16'd127;
    tv[4].bytes[7:0] = 8'h7F;
    tv[5].data[15:0] = 16'd1;
    tv[5].scale = 16'd1;
    tv[5].bytes[15:0] = 16'h817F;
    tick();
    tick();
    check("rst tvalid", m_axis_tvalid, 0);
    check("rst tready", s_axis_tready, 1);
    check("rst tscale", m_axis_tscale, 0);
    check("rst tlast", m_axis_tlast, 0);
    check_bytes("rst tdata", '0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      send(tv[i], $sformatf("vec%0d", i));
      finish_hs($sformatf("vec%0d", i));
    end
    send(tv[2], "stall");
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("stall tvalid", m_axis_tvalid, 1);
      check("stall in_ready", s_axis_tready, 0);
      check("stall scale", m_axis_tscale, tv[2].scale);
      check("stall tlast", m_axis_tlast, 1);
      check_bytes("stall tdata", tv[2].bytes);
    end
    s_axis_tvalid = 1'b0;
    finish_hs("stall");
`ifdef KV_COMPRESS_STATS_EN
    check("stat_vec pre", stat_vec_cnt, 7);
    check("stat_zero pre", stat_zero_cnt, 1);
`endif
    s_axis_tdata = tv[1].data;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    check("midrst tvalid", m_axis_tvalid, 0);
    check("midrst in_ready", s_axis_tready, 1);
`ifdef KV_COMPRESS_STATS_EN
    check("midrst stat_vec", stat_vec_cnt, 0);
    check("midrst stat_zero", stat_zero_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();
    send(tv[2], "after_rst");
    finish_hs("after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
